// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 word packer.
// Widths, FSM state and byte-valid helpers.
package sha256_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 512;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int SIZE_W          = 64;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Out-of-range byte counts mean a full word.
  function automatic logic [2:0] eff_nbytes(input logic [2:0] nb);
    return (nb == 3'd0 || nb > 3'd4) ? 3'd4 : nb;
  endfunction

  // Keep the leading nb bytes (byte 0 sits in the MSBs).
  function automatic logic [WORD_W-1:0] byte_mask(input logic [2:0] nb);
    logic [WORD_W-1:0] m;
    m = '1;
    unique case (1'b1)
      (nb == 3'd1): m = 32'hFF00_0000;
      (nb == 3'd2): m = 32'hFFFF_0000;
      (nb == 3'd3): m = 32'hFFFF_FF00;
      default:      m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sha256_word_packer_if.sv
// Word input, block output and config handshakes of the packer.
// master = packer side, slave = environment side.
interface sha256_word_packer_if;
  import sha256_pkg::*;

  logic [WORD_W-1:0]  word_in;
  logic [2:0]         word_in_nbytes;
  logic               word_in_last;
  logic               word_in_valid;
  logic               word_in_ready;

  logic [BLOCK_W-1:0] data_out;
  logic               data_out_last;
  logic               data_out_valid;
  logic               data_out_ready;

  logic [SIZE_W-1:0]  cfg_size;
  logic [1:0]         cfg_scheme;
  logic               cfg_last;
  logic               cfg_valid;
  logic               cfg_ready;

  modport master (
    input  word_in, word_in_nbytes, word_in_last,
    input  word_in_valid, data_out_ready, cfg_ready,
    output word_in_ready, data_out, data_out_last,
    output data_out_valid, cfg_size, cfg_scheme,
    output cfg_last, cfg_valid
  );

  modport slave (
    output word_in, word_in_nbytes, word_in_last,
    output word_in_valid, data_out_ready, cfg_ready,
    input  word_in_ready, data_out, data_out_last,
    input  data_out_valid, cfg_size, cfg_scheme,
    input  cfg_last, cfg_valid
  );

endinterface

// File: rtl/sha256_word_packer.sv
// Packs 32-bit message words into 512-bit blocks and
// reports the message bit length once per message.
module sha256_word_packer
  import sha256_pkg::*;
#(
  parameter logic [1:0] CFG_SCHEME = 2'b00
) (
  input  logic                 clk,
  input  logic                 sync_rst,
  input  logic                 en,
  sha256_word_packer_if.master bus
);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q;
  logic [BLOCK_W-1:0] blk_q;
  logic               last_q;
  logic [SIZE_W-1:0]  bits_q;
  logic [SIZE_W-1:0]  size_q;
  logic               cfg_pend_q;

  logic               in_fire;
  logic               out_fire;
  logic               cfg_fire;
  logic [2:0]         nb;
  logic [WORD_W-1:0]  wmask;
  logic [5:0]         add;
  logic [8:0]         slot_lsb;

  assign bus.word_in_ready  = en & ~sync_rst & ~cfg_pend_q
                            & (state_q == FILL);
  assign bus.data_out_valid = en & (state_q == EMIT);
  assign bus.cfg_valid      = en & cfg_pend_q;
  assign bus.data_out       = blk_q;
  assign bus.data_out_last  = last_q;
  assign bus.cfg_size       = size_q;
  assign bus.cfg_scheme     = CFG_SCHEME;
  assign bus.cfg_last       = 1'b1;

  assign in_fire  = bus.word_in_valid & bus.word_in_ready;
  assign out_fire = bus.data_out_valid & bus.data_out_ready;
  assign cfg_fire = bus.cfg_valid & bus.cfg_ready;

  assign nb       = eff_nbytes(bus.word_in_nbytes);
  assign wmask    = bus.word_in_last ? byte_mask(nb) : '1;
  assign add      = bus.word_in_last ? {nb, 3'b000} : 6'd32;
  // Slot 0 lands in the MSBs: offset = (15 - cnt) * 32.
  assign slot_lsb = {~cnt_q, 5'b00000};

  // State register.
  always_ff @(posedge clk) begin
    if (sync_rst) state_q <= FILL;
    else          state_q <= state_d;
  end

  // Block full or message end -> EMIT; block taken -> FILL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (in_fire && (bus.word_in_last || cnt_q == 4'd15))
              state_d = EMIT;
      EMIT: if (out_fire) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Block assembly, bit counting and config hold.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt_q      <= '0;
      blk_q      <= '0;
      last_q     <= 1'b0;
      bits_q     <= '0;
      size_q     <= '0;
      cfg_pend_q <= 1'b0;
    end else if (en) begin
      if (out_fire) begin
        blk_q  <= '0;
        cnt_q  <= '0;
        last_q <= 1'b0;
      end
      if (cfg_fire) cfg_pend_q <= 1'b0;
      if (in_fire) begin
        blk_q[slot_lsb +: WORD_W] <= bus.word_in & wmask;
        cnt_q <= cnt_q + 4'd1;
        if (bus.word_in_last) begin
          last_q     <= 1'b1;
          size_q     <= bits_q + SIZE_W'(add);
          cfg_pend_q <= 1'b1;
          bits_q     <= '0;
        end else begin
          bits_q <= bits_q + SIZE_W'(add);
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_word_packer.sv
// Directed self-checking bench for sha256_word_packer.
// Expected blocks are built from the words the bench sends.
module tb_sha256_word_packer;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic sync_rst;
  logic en;
  int   checks = 0;
  int   errors = 0;
  logic [511:0] exp_blk;
  logic [511:0] snap;

  sha256_word_packer_if bus_if ();

  sha256_word_packer #(.CFG_SCHEME(2'b00)) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .en       (en),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_slot(input int i, input logic [31:0] w);
    exp_blk[511 - 32*i -: 32] = w;
  endtask

  // Offer one word at a falling edge, wait for acceptance.
  task automatic push(input logic [31:0] w, input logic l,
                      input logic [2:0] nb);
    int n;
    n = 0;
    bus_if.word_in        = w;
    bus_if.word_in_last   = l;
    bus_if.word_in_nbytes = nb;
    bus_if.word_in_valid  = 1'b1;
    #1;
    while (!bus_if.word_in_ready && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 60) chk("push_timeout", 1'b0, 1'b1);
    @(negedge clk);
    bus_if.word_in_valid = 1'b0;
    bus_if.word_in_last  = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
  endtask

  initial begin
    sync_rst = 1'b1;
    en       = 1'b1;
    bus_if.word_in        = '0;
    bus_if.word_in_nbytes = 3'd4;
    bus_if.word_in_last   = 1'b0;
    bus_if.word_in_valid  = 1'b0;
    bus_if.data_out_ready = 1'b1;
    bus_if.cfg_ready      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready_low", bus_if.word_in_ready, 1'b0);
    sync_rst = 1'b0;
    #1;
    chk("rst_dvalid", bus_if.data_out_valid, 1'b0);
    chk("rst_cvalid", bus_if.cfg_valid, 1'b0);
    chk("rst_data", bus_if.data_out, '0);
    chk("rst_size", bus_if.cfg_size, '0);
    chk("rst_ready", bus_if.word_in_ready, 1'b1);
    @(negedge clk);

    // Full 16-word message.
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      push(32'(i), i == 15, 3'd4);
      put_slot(i, 32'(i));
    end
    chk("m16_dvalid", bus_if.data_out_valid, 1'b1);
    chk("m16_cvalid", bus_if.cfg_valid, 1'b1);
    chk("m16_w0", bus_if.data_out[511:480], 32'h0);
    chk("m16_w15", bus_if.data_out[31:0], 32'hF);
    chk("m16_blk", bus_if.data_out, exp_blk);
    chk("m16_last", bus_if.data_out_last, 1'b1);
    chk("m16_size", bus_if.cfg_size, 64'd512);
    chk("m16_scheme", bus_if.cfg_scheme, 2'b00);
    chk("m16_clast", bus_if.cfg_last, 1'b1);
    drain();
    chk("m16_done", bus_if.data_out_valid, 1'b0);
    chk("m16_cdone", bus_if.cfg_valid, 1'b0);

    // 20-word message, partial last word.
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      push(32'h100 + 32'(i), 1'b0, 3'd4);
      put_slot(i, 32'h100 + 32'(i));
    end
    chk("m20_b1_valid", bus_if.data_out_valid, 1'b1);
    chk("m20_b1_blk", bus_if.data_out, exp_blk);
    chk("m20_b1_last", bus_if.data_out_last, 1'b0);
    chk("m20_b1_cfg", bus_if.cfg_valid, 1'b0);
    exp_blk = '0;
    for (int i = 16; i < 19; i++) begin
      push(32'h100 + 32'(i), 1'b0, 3'd4);
      put_slot(i - 16, 32'h100 + 32'(i));
    end
    push(32'hAABBCCDD, 1'b1, 3'd2);
    put_slot(3, 32'hAABB0000);
    chk("m20_b2_blk", bus_if.data_out, exp_blk);
    chk("m20_b2_slot3", bus_if.data_out[415:384], 32'hAABB0000);
    chk("m20_b2_last", bus_if.data_out_last, 1'b1);
    chk("m20_size", bus_if.cfg_size, 64'd624);
    chk("m20_cvalid", bus_if.cfg_valid, 1'b1);
    drain();

    // Backpressure on data_out, then on cfg.
    bus_if.data_out_ready = 1'b0;
    bus_if.cfg_ready      = 1'b0;
    exp_blk = '0;
    push(32'h1, 1'b0, 3'd4);
    push(32'h2, 1'b0, 3'd4);
    push(32'h3, 1'b1, 3'd4);
    put_slot(0, 32'h1);
    put_slot(1, 32'h2);
    put_slot(2, 32'h3);
    snap = bus_if.data_out;
    chk("bp_blk", snap, exp_blk);
    bus_if.word_in       = 32'h55;
    bus_if.word_in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("bp_stable", bus_if.data_out, exp_blk);
      chk("bp_hold_valid", bus_if.data_out_valid, 1'b1);
      chk("bp_no_ready", bus_if.word_in_ready, 1'b0);
    end
    bus_if.word_in_valid  = 1'b0;
    bus_if.data_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", bus_if.data_out_valid, 1'b0);
    chk("bp_cfg_pend", bus_if.cfg_valid, 1'b1);
    chk("bp_size", bus_if.cfg_size, 64'd96);
    bus_if.word_in        = 32'h61626364;
    bus_if.word_in_nbytes = 3'd3;
    bus_if.word_in_last   = 1'b1;
    bus_if.word_in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("cfg_block_ready", bus_if.word_in_ready, 1'b0);
      @(negedge clk);
    end
    bus_if.cfg_ready = 1'b1;
    exp_blk = '0;
    put_slot(0, 32'h61626300);
    push(32'h61626364, 1'b1, 3'd3);
    chk("cfg_after_blk", bus_if.data_out, exp_blk);
    chk("cfg_after_size", bus_if.cfg_size, 64'd24);
    drain();

    // Reset mid-message discards it.
    for (int i = 0; i < 7; i++) push(32'hDEAD0000 + 32'(i), 1'b0, 3'd4);
    chk("abort_no_valid", bus_if.data_out_valid, 1'b0);
    sync_rst = 1'b1;
    @(negedge clk);
    sync_rst = 1'b0;
    #1;
    chk("abort_dvalid", bus_if.data_out_valid, 1'b0);
    chk("abort_cvalid", bus_if.cfg_valid, 1'b0);
    @(negedge clk);
    exp_blk = '0;
    put_slot(0, 32'h61000000);
    push(32'h61000000, 1'b1, 3'd1);
    chk("abort_blk", bus_if.data_out, exp_blk);
    chk("abort_size", bus_if.cfg_size, 64'd8);
    chk("abort_last", bus_if.data_out_last, 1'b1);
    drain();

    // nbytes 0 and 7 both mean 4.
    exp_blk = '0;
    put_slot(0, 32'h12345678);
    push(32'h12345678, 1'b1, 3'd0);
    chk("nb0_blk", bus_if.data_out, exp_blk);
    chk("nb0_size", bus_if.cfg_size, 64'd32);
    drain();
    exp_blk = '0;
    put_slot(0, 32'h9ABCDEF0);
    push(32'h9ABCDEF0, 1'b1, 3'd7);
    chk("nb7_blk", bus_if.data_out, exp_blk);
    chk("nb7_size", bus_if.cfg_size, 64'd32);
    drain();

    // Enable low mid-message.
    exp_blk = '0;
    push(32'h200, 1'b0, 3'd4);
    push(32'h201, 1'b0, 3'd4);
    bus_if.word_in        = 32'h202;
    bus_if.word_in_nbytes = 3'd4;
    bus_if.word_in_last   = 1'b0;
    bus_if.word_in_valid  = 1'b1;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("en_ready", bus_if.word_in_ready, 1'b0);
      chk("en_dvalid", bus_if.data_out_valid, 1'b0);
      chk("en_cvalid", bus_if.cfg_valid, 1'b0);
      @(negedge clk);
    end
    en = 1'b1;
    push(32'h202, 1'b0, 3'd4);
    push(32'h203, 1'b0, 3'd4);
    push(32'h204, 1'b1, 3'd3);
    for (int i = 0; i < 4; i++) put_slot(i, 32'h200 + 32'(i));
    put_slot(4, 32'h200);
    chk("en_blk", bus_if.data_out, exp_blk);
    chk("en_size", bus_if.cfg_size, 64'd152);
    chk("en_dv", bus_if.data_out_valid, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_word_packer.md
SHA256_WORD_PACKER -- requirements
Module: sha256_word_packer

Interface
REQ-001 Parameter: CFG_SCHEME, default 2'b00, value driven on cfg_scheme for every message.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock; sole clock.
REQ-004 sync_rst  in  1  synchronous active-high reset.
REQ-005 en  in  1  clock enable.
REQ-006 word_in  in  32  message word; byte 0 at [31:24].
REQ-007 word_in_nbytes  in  3  valid bytes in the last word (1-4); ignored unless word_in_last.
REQ-008 word_in_last  in  1  final word of the message.
REQ-009 word_in_valid / word_in_ready  in / out  1 each  input handshake.
REQ-010 data_out  out  512  packed block; word 0 at [511:480].
REQ-011 data_out_last  out  1  block holds the message's final word.
REQ-012 data_out_valid / data_out_ready  out / in  1 each  block handshake.
REQ-013 cfg_size  out  64  message length in bits.
REQ-014 cfg_scheme  out  2  equals CFG_SCHEME.
REQ-015 cfg_last  out  1  always 1 when cfg_valid is 1 (one config per message).
REQ-016 cfg_valid / cfg_ready  out / in  1 each  config handshake.

Function
REQ-017 The FSM SHALL have the states FILL and EMIT. A transfer SHALL occur only on a clock edge with valid, ready and en all high.
REQ-018 In FILL, word_in_ready SHALL equal en and not cfg_valid. In EMIT, word_in_ready SHALL be 0.
REQ-019 Each accepted word SHALL be written to block slot word_cnt (0-15), and word_cnt SHALL then increment.
REQ-020 Accepting the 16th word, or a word with word_in_last, SHALL move the FSM to EMIT with data_out_valid=1 on the next cycle. Latency is 1 cycle.
REQ-021 Unfilled slots SHALL read zero. Bytes of the last word beyond word_in_nbytes SHALL read zero.
REQ-022 A word_in_nbytes value of 0 or greater than 4 SHALL be treated as 4.
REQ-023 data_out and data_out_last SHALL stay stable while valid is high and ready is low.
REQ-024 The data_out handshake SHALL return the FSM to FILL, clear the block and set word_cnt to 0. Throughput is 16 words per 17 cycles.
REQ-025 The bit counter SHALL add 32 per full word and 8*nbytes for the last word, modulo 2^64 (wrap allowed).
REQ-026 Accepting the last word SHALL load cfg_size with the final count and assert cfg_valid in the same cycle as data_out_valid. The counter SHALL then clear.
REQ-027 cfg_valid SHALL hold until the cfg handshake. It is independent of the data_out handshake.
REQ-028 A new message SHALL NOT start while cfg_valid is pending.
REQ-029 When en is 0, all registers SHALL freeze and word_in_ready, data_out_valid and cfg_valid SHALL read 0.
REQ-030 Zero-length messages are unsupported. Any word with word_in_last carries at least 1 byte.

Reset
REQ-031 sync_rst high at a clock edge SHALL set: state FILL, word_cnt 0, bit counter 0, data_out 0, data_out_last 0, data_out_valid 0, cfg_size 0, cfg_valid 0.
REQ-032 word_in_ready SHALL read 0 while sync_rst is high.
REQ-033 sync_rst SHALL take priority over en.
REQ-034 A reset mid-message SHALL discard the partial block and any pending config without emitting them.

Structure
REQ-035 Package sha256_pkg SHALL hold: WORD_W=32, BLOCK_W=512, WORDS_PER_BLOCK=16, SIZE_W=64, and the FSM state enum.
REQ-036 The block SHALL be a single module with no sub-module. Its output feeds the engine's data_in and cfg ports directly.

Verification
REQ-037 16 words 0x0-0xF, last on word 16 with nbytes=4 -> one block, [511:480]=0x0, [31:0]=0xF, data_out_last=1, cfg_size=512, cfg_valid in the same cycle.
REQ-038 20 words, last=0xAABBCCDD with nbytes=2 -> block 1 has last=0. Block 2: slot 3=0xAABB0000, slots 4-15=0, last=1. cfg_size=624.
REQ-039 data_out_ready low for 10 cycles during EMIT -> data_out stable and word_in_ready=0 throughout. cfg_ready held low while the next message is offered -> no word accepted until the cfg handshake.
REQ-040 sync_rst after 7 words, then a 1-word message 0x61000000 with nbytes=1 -> one block [511:480]=0x61000000, rest 0, cfg_size=8. No output from the aborted message.
REQ-041 en low for 5 cycles mid-message -> no transfers and all valid/ready outputs read 0; the final block and cfg_size equal the run without the en-low gap.
